moldudp_frame_sequencer: RTL

// Frame-level controller for the ITCH/MoldUDP64 header parser. Counts 64-bit beats of each

---
 rtl/itch_pkg.sv | 36 +++
 rtl/moldudp_frame_sequencer_seq_tracker.sv | 48 ++++
 rtl/moldudp_frame_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/itch_pkg.sv
// Shared types and constants for the MoldUDP64 frame sequencer.
package itch_pkg;

    // Why a frame was discarded.
    typedef enum logic [2:0] {
        DR_SHORT   = 3'd0,
        DR_ETYPE   = 3'd1,
        DR_PROTO   = 3'd2,
        DR_PORT    = 3'd3,
        DR_SESSION = 3'd4,
        DR_DUP     = 3'd5
    } drop_reason_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CHECK,
        S_PAYLOAD,
        S_DROP
    } state_e;

    localparam logic [15:0] UDP_PORT_MOLD = 16'd26400;
    localparam logic [15:0] ETYPE_IPV4    = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
    // 66-byte header spans beats 0..8; beat 8 carries messageCount.
    localparam logic [6:0]  HDR_LAST_BEAT = 7'd8;
    localparam logic [6:0]  BEAT_CNT_MAX  = 7'd127;
    localparam logic [15:0] MSG_COUNT_HB  = 16'h0000;
    localparam logic [15:0] MSG_COUNT_EOS = 16'hFFFF;

    // Beat counter increment that sticks at its maximum.
    function automatic logic [6:0] satInc(input logic [6:0] c);
        return (c == BEAT_CNT_MAX) ? c : c + 7'd1;
    endfunction

endpackage

// File: rtl/moldudp_frame_sequencer_seq_tracker.sv
// Session sequence-number bookkeeping: expected sequence, gap count and
// session lock. Compare results are combinational; state moves only when
// the frame sequencer strobes an accepted header.
module seq_tracker
    import itch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        update,
    input  logic        sessionLock,
    input  logic [79:0] sessionId,
    input  logic [63:0] seqNum,
    input  logic [15:0] msgCount,
    output logic        sessMismatch,
    output logic        seqDup,
    output logic        seqGap,
    output logic [63:0] expectedSeq,
    output logic        seqValid,
    output logic [15:0] gapCount
);

    logic [79:0] lockedSession;

    // Nothing is a duplicate or gap until the first header has been accepted.
    assign sessMismatch = sessionLock && seqValid && (sessionId != lockedSession);
    assign seqDup       = seqValid && (seqNum < expectedSeq);
    assign seqGap       = seqValid && (seqNum > expectedSeq);

    // Advance sequence state on each accepted header.
    always_ff @(posedge clk) begin
        if (rst) begin
            expectedSeq   <= '0;
            seqValid      <= 1'b0;
            gapCount      <= '0;
            lockedSession <= '0;
        end else if (update) begin
            if (seqGap && gapCount != 16'hFFFF)
                gapCount <= gapCount + 16'd1;
            // Heartbeat and end-of-session carry no messages to consume.
            if (msgCount != MSG_COUNT_HB && msgCount != MSG_COUNT_EOS)
                expectedSeq <= seqNum + {48'd0, msgCount};
            if (!seqValid)
                lockedSession <= sessionId;
            seqValid <= 1'b1;
        end
    end

endmodule

// File: rtl/moldudp_frame_sequencer.sv
// Frame-level controller for the MoldUDP64 header parser: counts beats,
// validates parsed header fields in a one-cycle CHECK slot, tracks
// sequence numbers and forwards accepted payload beats.
module moldudp_frame_sequencer
    import itch_pkg::*;
#(
    parameter logic [15:0] CFG_UDP_PORT = UDP_PORT_MOLD,
    parameter logic [15:0] CFG_ETYPE    = ETYPE_IPV4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] rx_data_net,
    input  logic        rx_valid,
    input  logic        rx_last,
    output logic        rx_ready,
    output logic [6:0]  counterOut,
    input  logic [15:0] eType_out,
    input  logic [7:0]  protocol_out,
    input  logic [15:0] destPort_out,
    input  logic [79:0] sessionID_out,
    input  logic [63:0] sequenceNumber_out,
    input  logic [15:0] messageCount_out,
    input  logic        session_lock,
    output logic        pkt_accept,
    output logic        pkt_drop,
    output logic [2:0]  drop_reason,
    output logic        gap_detected,
    output logic [15:0] gap_count,
    output logic [63:0] expected_seq,
    output logic        end_of_session,
    output logic [63:0] payload_data,
    output logic        payload_valid,
    output logic        payload_first,
    output logic        payload_last
);

    state_e       state;
    logic [63:0]  holdData;
    logic         holdLast;
    logic         beatAcc;
    logic         failAny;
    drop_reason_e failReason;
    logic         sessMismatch;
    logic         seqDup;
    logic         seqGap;
    logic         seqValid;
    logic         seqUpdate;
    logic         countNormal;

    // The only stall is the single header-check cycle.
    assign rx_ready    = (state != S_CHECK);
    assign beatAcc     = rx_valid && rx_ready;
    assign countNormal = (messageCount_out != MSG_COUNT_HB) &&
                         (messageCount_out != MSG_COUNT_EOS);
    assign seqUpdate   = (state == S_CHECK) && !failAny;

    // Header checks in priority order; first failure names the reason.
    always_comb begin
        failAny    = 1'b1;
        failReason = DR_ETYPE;
        if (eType_out != CFG_ETYPE)             failReason = DR_ETYPE;
        else if (protocol_out != IP_PROTO_UDP)  failReason = DR_PROTO;
        else if (destPort_out != CFG_UDP_PORT)  failReason = DR_PORT;
        else if (sessMismatch)                  failReason = DR_SESSION;
        else if (seqDup)                        failReason = DR_DUP;
        else                                    failAny    = 1'b0;
    end

    seq_tracker uTracker (
        .clk         (clk),
        .rst         (rst),
        .update      (seqUpdate),
        .sessionLock (session_lock),
        .sessionId   (sessionID_out),
        .seqNum      (sequenceNumber_out),
        .msgCount    (messageCount_out),
        .sessMismatch(sessMismatch),
        .seqDup      (seqDup),
        .seqGap      (seqGap),
        .expectedSeq (expected_seq),
        .seqValid    (seqValid),
        .gapCount    (gap_count)
    );

    // Frame FSM with registered pulses, beat counter and payload stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            counterOut     <= '0;
            holdData       <= '0;
            holdLast       <= 1'b0;
            pkt_accept     <= 1'b0;
            pkt_drop       <= 1'b0;
            drop_reason    <= DR_SHORT;
            gap_detected   <= 1'b0;
            end_of_session <= 1'b0;
            payload_data   <= '0;
            payload_valid  <= 1'b0;
            payload_first  <= 1'b0;
            payload_last   <= 1'b0;
        end else begin
            pkt_accept    <= 1'b0;
            pkt_drop      <= 1'b0;
            gap_detected  <= 1'b0;
            payload_valid <= 1'b0;
            payload_first <= 1'b0;
            payload_last  <= 1'b0;
            case (state)
                S_IDLE, S_HDR: begin
                    if (beatAcc) begin
                        if (counterOut == HDR_LAST_BEAT) begin
                            // Beat 8 holds both the tail of the header and
                            // the start of payload; park it across CHECK.
                            holdData   <= rx_data_net;
                            holdLast   <= rx_last;
                            counterOut <= satInc(counterOut);
                            state      <= S_CHECK;
                        end else if (rx_last) begin
                            pkt_drop    <= 1'b1;
                            drop_reason <= DR_SHORT;
                            counterOut  <= '0;
                            state       <= S_IDLE;
                        end else begin
                            counterOut <= satInc(counterOut);
                            state      <= S_HDR;
                        end
                    end
                end
                S_CHECK: begin
                    if (failAny) begin
                        pkt_drop    <= 1'b1;
                        drop_reason <= failReason;
                        state       <= holdLast ? S_IDLE : S_DROP;
                    end else begin
                        pkt_accept   <= 1'b1;
                        gap_detected <= seqGap;
                        if (messageCount_out == MSG_COUNT_EOS)
                            end_of_session <= 1'b1;
                        if (countNormal) begin
                            payload_valid <= 1'b1;
                            payload_data  <= holdData;
                            payload_first <= 1'b1;
                            payload_last  <= holdLast;
                            state         <= holdLast ? S_IDLE : S_PAYLOAD;
                        end else begin
                            state <= holdLast ? S_IDLE : S_DROP;
                        end
                    end
                    if (holdLast)
                        counterOut <= '0;
                end
                S_PAYLOAD: begin
                    if (beatAcc) begin
                        payload_valid <= 1'b1;
                        payload_data  <= rx_data_net;
                        payload_last  <= rx_last;
                        if (rx_last) begin
                            counterOut <= '0;
                            state      <= S_IDLE;
                        end else begin
                            counterOut <= satInc(counterOut);
                        end
                    end
                end
                S_DROP: begin
                    if (beatAcc) begin
                        if (rx_last) begin
                            counterOut <= '0;
                            state      <= S_IDLE;
                        end else begin
                            counterOut <= satInc(counterOut);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
